// File: rtl/rc4_pkg.sv
// ---------------------------------------------------------------------------
// rc4_pkg
// Shared definitions for the RC4 key-search controller:
//   - state_t             : sequencer states (IDLE, INIT, SHUF, DEC, CHECK, DONE)
//   - CHAR_SPACE/LO/HI    : bounds of the accepted plaintext alphabet
//   - MESSAGE_LEN_DEFAULT : default decrypted message length in bytes
//   - is_msg_char()       : 1 when a byte is a space or a lowercase letter
// ---------------------------------------------------------------------------
package rc4_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        SHUF,
        DEC,
        CHECK,
        DONE
    } state_t;

    localparam logic [7:0] CHAR_SPACE = 8'h20;
    localparam logic [7:0] CHAR_LO    = 8'h61;
    localparam logic [7:0] CHAR_HI    = 8'h7A;

    localparam int MESSAGE_LEN_DEFAULT = 32;

    function automatic logic is_msg_char(input logic [7:0] c);
        return (c == CHAR_SPACE) || ((c >= CHAR_LO) && (c <= CHAR_HI));
    endfunction

endpackage

// File: rtl/msg_char_checker.sv
// ---------------------------------------------------------------------------
// msg_char_checker
// Sticky "bad" flag over the decrypted message bytes.
// Ports:
//   clk, reset          : clock, asynchronous active-high reset
//   clear               : synchronous clear, wins over a same-cycle set
//   enable              : only snoop result writes while high
//   res_addr/data/wren  : snooped result-RAM write
//   bad                 : 1 once any in-range byte is outside [a-z ]
// Writes at res_addr >= MESSAGE_LEN are outside the message and ignored.
// ---------------------------------------------------------------------------
module msg_char_checker
    import rc4_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 8,
    parameter int MESSAGE_LEN = MESSAGE_LEN_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  enable,
    input  logic [ADDR_WIDTH-1:0] res_addr,
    input  logic [DATA_WIDTH-1:0] res_data,
    input  logic                  res_wren,
    output logic                  bad
);

    // One extra bit so a MESSAGE_LEN of 2**ADDR_WIDTH still compares correctly.
    localparam logic [ADDR_WIDTH:0] LEN = MESSAGE_LEN[ADDR_WIDTH:0];

    logic in_message;
    assign in_message = ({1'b0, res_addr} < LEN);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bad <= 1'b0;
        end else if (clear) begin
            bad <= 1'b0;
        end else if (enable && res_wren && in_message && !is_msg_char(res_data)) begin
            bad <= 1'b1;
        end
    end

endmodule

// File: rtl/rc4_crack_ctrl.sv
// ---------------------------------------------------------------------------
// rc4_crack_ctrl
// Brute-force key-search sequencer. For every candidate key it runs the init,
// shuffle and decrypt stages in turn (4-phase start/finish handshakes), grants
// the single scratch RAM port to the active stage, and stops on the first key
// whose decrypted message consists only of lowercase letters and spaces.
// Ports:
//   clk, reset                 : clock, asynchronous active-high reset
//   start                      : rising edge launches a search
//   done, key_found, key_out   : result; key_out is the live candidate
//   {init,shuf,dec}_start/finish : stage handshakes
//   {init,shuf,dec}_s_*        : stage scratch requests
//   s_addr, s_data, s_wren     : muxed scratch RAM port
//   res_addr, res_data, res_wren : decrypter result writes, snooped
// Optional: define RC4_CRACK_STATS_EN to add keys_tried (CHECK cycles counted).
// ---------------------------------------------------------------------------
module rc4_crack_ctrl
    import rc4_pkg::*;
#(
    parameter int                  DATA_WIDTH  = 8,
    parameter int                  ADDR_WIDTH  = 8,
    parameter int                  MESSAGE_LEN = MESSAGE_LEN_DEFAULT,
    parameter int                  KEY_WIDTH   = 24,
    parameter logic [KEY_WIDTH-1:0] KEY_START  = 24'h000000,
    parameter logic [KEY_WIDTH-1:0] KEY_END    = 24'h3FFFFF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  done,
    output logic                  key_found,
    output logic [KEY_WIDTH-1:0]  key_out,
    output logic                  init_start,
    input  logic                  init_finish,
    output logic                  shuf_start,
    input  logic                  shuf_finish,
    output logic                  dec_start,
    input  logic                  dec_finish,
    input  logic [ADDR_WIDTH-1:0] init_s_addr,
    input  logic [DATA_WIDTH-1:0] init_s_data,
    input  logic                  init_s_wren,
    input  logic [ADDR_WIDTH-1:0] shuf_s_addr,
    input  logic [DATA_WIDTH-1:0] shuf_s_data,
    input  logic                  shuf_s_wren,
    input  logic [ADDR_WIDTH-1:0] dec_s_addr,
    input  logic [DATA_WIDTH-1:0] dec_s_data,
    input  logic                  dec_s_wren,
    output logic [ADDR_WIDTH-1:0] s_addr,
    output logic [DATA_WIDTH-1:0] s_data,
    output logic                  s_wren,
    input  logic [ADDR_WIDTH-1:0] res_addr,
    input  logic [DATA_WIDTH-1:0] res_data,
    input  logic                  res_wren
`ifdef RC4_CRACK_STATS_EN
   ,output logic [KEY_WIDTH:0]    keys_tried
`endif
);

    state_t state;
    // phase 0: start high, waiting for finish; phase 1: start low, waiting for finish to drop
    logic   phase;
    logic   start_q;
    logic   start_edge;
    logic   bad;
    logic   bad_clear;

    assign start_edge = start & ~start_q;

    // Clear on a new search and on the SHUF -> DEC transition, so each key's
    // verdict covers exactly its own decryption.
    assign bad_clear = (((state == IDLE) || (state == DONE)) && start_edge) ||
                       ((state == SHUF) && phase && !shuf_finish);

    msg_char_checker #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .MESSAGE_LEN(MESSAGE_LEN)
    ) u_checker (
        .clk     (clk),
        .reset   (reset),
        .clear   (bad_clear),
        .enable  (state == DEC),
        .res_addr(res_addr),
        .res_data(res_data),
        .res_wren(res_wren),
        .bad     (bad)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            phase      <= 1'b0;
            start_q    <= 1'b0;
            init_start <= 1'b0;
            shuf_start <= 1'b0;
            dec_start  <= 1'b0;
            done       <= 1'b0;
            key_found  <= 1'b0;
            key_out    <= KEY_START;
`ifdef RC4_CRACK_STATS_EN
            keys_tried <= '0;
`endif
        end else begin
            start_q <= start;
            case (state)
                IDLE, DONE: begin
                    if (start_edge) begin
                        state      <= INIT;
                        phase      <= 1'b0;
                        init_start <= 1'b1;
                        done       <= 1'b0;
                        key_found  <= 1'b0;
                        key_out    <= KEY_START;
`ifdef RC4_CRACK_STATS_EN
                        keys_tried <= '0;
`endif
                    end
                end
                INIT: begin
                    if (!phase) begin
                        if (init_finish) begin
                            init_start <= 1'b0;
                            phase      <= 1'b1;
                        end
                    end else if (!init_finish) begin
                        phase      <= 1'b0;
                        state      <= SHUF;
                        shuf_start <= 1'b1;
                    end
                end
                SHUF: begin
                    if (!phase) begin
                        if (shuf_finish) begin
                            shuf_start <= 1'b0;
                            phase      <= 1'b1;
                        end
                    end else if (!shuf_finish) begin
                        phase     <= 1'b0;
                        state     <= DEC;
                        dec_start <= 1'b1;
                    end
                end
                DEC: begin
                    if (!phase) begin
                        if (dec_finish) begin
                            dec_start <= 1'b0;
                            phase     <= 1'b1;
                        end
                    end else if (!dec_finish) begin
                        phase <= 1'b0;
                        state <= CHECK;
                    end
                end
                CHECK: begin
`ifdef RC4_CRACK_STATS_EN
                    keys_tried <= keys_tried + 1'b1;
`endif
                    if (!bad) begin
                        key_found <= 1'b1;
                        done      <= 1'b1;
                        state     <= DONE;
                    end else if (key_out == KEY_END) begin
                        key_found <= 1'b0;
                        done      <= 1'b1;
                        state     <= DONE;
                    end else begin
                        key_out    <= key_out + 1'b1;
                        state      <= INIT;
                        init_start <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    phase <= 1'b0;
                end
            endcase
        end
    end

    // Scratch port grant follows the registered state; idle states park the port.
    always_comb begin
        s_addr = '0;
        s_data = '0;
        s_wren = 1'b0;
        case (state)
            INIT: begin
                s_addr = init_s_addr;
                s_data = init_s_data;
                s_wren = init_s_wren;
            end
            SHUF: begin
                s_addr = shuf_s_addr;
                s_data = shuf_s_data;
                s_wren = shuf_s_wren;
            end
            DEC: begin
                s_addr = dec_s_addr;
                s_data = dec_s_data;
                s_wren = dec_s_wren;
            end
            default: begin
                s_addr = '0;
                s_data = '0;
                s_wren = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_rc4_crack_ctrl.sv
// ---------------------------------------------------------------------------
// tb_rc4_crack_ctrl
// Directed and randomized bench for rc4_crack_ctrl with KEY_START=0, KEY_END=5.
// Stage stubs finish 3 cycles after start; the decrypter stub writes the
// bench-chosen message for the current key, then one extra write at address 32.
// Define RC4_CRACK_STATS_EN to also check keys_tried.
// ---------------------------------------------------------------------------
module tb_rc4_crack_ctrl;

    localparam int NKEYS = 6;
    localparam int MLEN  = 32;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        done, key_found;
    logic [23:0] key_out;
    logic        init_start, init_finish;
    logic        shuf_start, shuf_finish;
    logic        dec_start, dec_finish;
    logic [7:0]  init_s_addr, init_s_data;
    logic        init_s_wren;
    logic [7:0]  shuf_s_addr, shuf_s_data;
    logic        shuf_s_wren;
    logic [7:0]  dec_s_addr, dec_s_data;
    logic        dec_s_wren;
    logic [7:0]  s_addr, s_data;
    logic        s_wren;
    logic [7:0]  res_addr, res_data;
    logic        res_wren;
`ifdef RC4_CRACK_STATS_EN
    logic [24:0] keys_tried;
`endif

    logic [7:0] msg [0:NKEYS-1][0:MLEN-1];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    rc4_crack_ctrl #(
        .DATA_WIDTH (8),
        .ADDR_WIDTH (8),
        .MESSAGE_LEN(MLEN),
        .KEY_WIDTH  (24),
        .KEY_START  (24'd0),
        .KEY_END    (24'd5)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .done       (done),
        .key_found  (key_found),
        .key_out    (key_out),
        .init_start (init_start),
        .init_finish(init_finish),
        .shuf_start (shuf_start),
        .shuf_finish(shuf_finish),
        .dec_start  (dec_start),
        .dec_finish (dec_finish),
        .init_s_addr(init_s_addr),
        .init_s_data(init_s_data),
        .init_s_wren(init_s_wren),
        .shuf_s_addr(shuf_s_addr),
        .shuf_s_data(shuf_s_data),
        .shuf_s_wren(shuf_s_wren),
        .dec_s_addr (dec_s_addr),
        .dec_s_data (dec_s_data),
        .dec_s_wren (dec_s_wren),
        .s_addr     (s_addr),
        .s_data     (s_data),
        .s_wren     (s_wren),
        .res_addr   (res_addr),
        .res_data   (res_data),
        .res_wren   (res_wren)
`ifdef RC4_CRACK_STATS_EN
       ,.keys_tried (keys_tried)
`endif
    );

    // Init and shuffle stubs: finish 3 cycles after start, drop finish once start drops.
    initial begin : init_stub
        int cnt;
        init_finish = 1'b0;
        cnt = 0;
        forever begin
            @(negedge clk);
            if (!init_start) begin
                init_finish = 1'b0;
                cnt = 0;
            end else if (!init_finish) begin
                cnt++;
                if (cnt >= 3) init_finish = 1'b1;
            end
        end
    end

    initial begin : shuf_stub
        int cnt;
        shuf_finish = 1'b0;
        cnt = 0;
        forever begin
            @(negedge clk);
            if (!shuf_start) begin
                shuf_finish = 1'b0;
                cnt = 0;
            end else if (!shuf_finish) begin
                cnt++;
                if (cnt >= 3) shuf_finish = 1'b1;
            end
        end
    end

    // Decrypter stub: writes msg[key] to result addresses 0..31, then 8'h00 at 32.
    initial begin : dec_stub
        int cnt;
        dec_finish = 1'b0;
        res_wren = 1'b0;
        res_addr = 8'h00;
        res_data = 8'h00;
        cnt = 0;
        forever begin
            @(negedge clk);
            res_wren = 1'b0;
            if (!dec_start) begin
                dec_finish = 1'b0;
                cnt = 0;
            end else if (!dec_finish) begin
                if (cnt < MLEN) begin
                    res_wren = 1'b1;
                    res_addr = cnt[7:0];
                    res_data = msg[key_out[2:0]][cnt];
                end else if (cnt == MLEN) begin
                    res_wren = 1'b1;
                    res_addr = 8'd32;
                    res_data = 8'h00;
                end else if (cnt >= MLEN + 3) begin
                    dec_finish = 1'b1;
                end
                cnt++;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            #1;
        end
    endtask

    function automatic logic probe(input int which);
        case (which)
            0: return init_start;
            1: return shuf_start;
            2: return dec_start;
            3: return done;
            default: return (!dec_start && !dec_finish);
        endcase
    endfunction

    task automatic waitFor(input int which, input logic val, input string tag);
        int n;
        n = 0;
        while ((probe(which) !== val) && (n < 3000)) begin
            step(1);
            n++;
        end
        checkOutput(tag, {31'd0, probe(which)}, {31'd0, val});
    endtask

    // Reference view of the plaintext rule.
    function automatic logic good_char(input logic [7:0] c);
        return (c == " ") || ((c >= "a") && (c <= "z"));
    endfunction

    function automatic logic [7:0] rand_good();
        int r;
        r = $urandom_range(0, 26);
        return (r == 26) ? 8'h20 : 8'(8'h61 + r);
    endfunction

    function automatic logic [7:0] rand_bad();
        logic [7:0] c;
        c = 8'($urandom_range(0, 255));
        while (good_char(c)) c = 8'($urandom_range(0, 255));
        return c;
    endfunction

    task automatic fillGood(input int k);
        for (int i = 0; i < MLEN; i++) msg[k][i] = rand_good();
    endtask

    task automatic fillBad(input int k, input logic [7:0] c);
        fillGood(k);
        msg[k][$urandom_range(0, MLEN - 1)] = c;
    endtask

    // First key whose whole message is acceptable; NKEYS when none is.
    function automatic int firstGoodKey();
        for (int k = 0; k < NKEYS; k++) begin
            logic ok;
            ok = 1'b1;
            for (int i = 0; i < MLEN; i++) if (!good_char(msg[k][i])) ok = 1'b0;
            if (ok) return k;
        end
        return NKEYS;
    endfunction

    task automatic applyStimulus();
        start = 1'b0;
        step(1);
        start = 1'b1;
        step(1);
    endtask

    task automatic checkResult(input string tag);
        int exp_k;
        exp_k = firstGoodKey();
        waitFor(3, 1'b1, {tag, "_done"});
        checkOutput({tag, "_found"}, {31'd0, key_found}, (exp_k < NKEYS) ? 32'd1 : 32'd0);
        checkOutput({tag, "_key"}, {8'd0, key_out}, (exp_k < NKEYS) ? exp_k : NKEYS - 1);
`ifdef RC4_CRACK_STATS_EN
        checkOutput({tag, "_tried"}, {7'd0, keys_tried}, (exp_k < NKEYS) ? exp_k + 1 : NKEYS);
`endif
    endtask

    task automatic loadScenarioA();
        fillBad(0, 8'h60);
        fillBad(1, 8'h7B);
        fillBad(2, rand_bad());
        fillGood(3);
        msg[3][0] = 8'h61; msg[3][1] = 8'h62; msg[3][2] = 8'h20;
        msg[3][3] = 8'h63; msg[3][4] = 8'h64; msg[3][5] = 8'h7A;
        fillGood(4);
        fillGood(5);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        init_s_addr = 8'h11; init_s_data = 8'hAA; init_s_wren = 1'b1;
        shuf_s_addr = 8'h22; shuf_s_data = 8'hBB; shuf_s_wren = 1'b1;
        dec_s_addr  = 8'h33; dec_s_data  = 8'hCC; dec_s_wren  = 1'b1;
        step(3);
        checkOutput("rst_done", {31'd0, done}, 32'd0);
        checkOutput("rst_found", {31'd0, key_found}, 32'd0);
        checkOutput("rst_key", {8'd0, key_out}, 32'd0);
        checkOutput("rst_starts", {29'd0, init_start, shuf_start, dec_start}, 32'd0);
        checkOutput("rst_swren", {31'd0, s_wren}, 32'd0);
        reset = 1'b0;
        step(2);

        // Scenario A: key 3 is the first valid one; scratch mux checked along the way.
        loadScenarioA();
        start = 1'b1;
        waitFor(0, 1'b1, "a_init_start");
        checkOutput("init_saddr", {24'd0, s_addr}, 32'h11);
        checkOutput("init_sdata", {24'd0, s_data}, 32'hAA);
        checkOutput("init_swren", {31'd0, s_wren}, 32'd1);
        waitFor(1, 1'b1, "a_shuf_start");
        shuf_s_wren = 1'b0;
        #1;
        checkOutput("shuf_swren0", {31'd0, s_wren}, 32'd0);
        shuf_s_wren = 1'b1;
        #1;
        checkOutput("shuf_swren1", {31'd0, s_wren}, 32'd1);
        checkOutput("shuf_saddr", {24'd0, s_addr}, 32'h22);
        waitFor(2, 1'b1, "a_dec_start");
        checkOutput("dec_saddr", {24'd0, s_addr}, 32'h33);
        checkOutput("dec_sdata", {24'd0, s_data}, 32'hCC);
        waitFor(4, 1'b1, "a_dec_idle");
        step(1);
        checkOutput("check_swren", {31'd0, s_wren}, 32'd0);
        checkOutput("check_saddr", {24'd0, s_addr}, 32'd0);
        checkOutput("check_key", {8'd0, key_out}, 32'd0);
        checkResult("a");

        // start still high: no retrigger from DONE.
        step(20);
        checkOutput("hold_done", {31'd0, done}, 32'd1);
        checkOutput("hold_init", {31'd0, init_start}, 32'd0);
        checkOutput("hold_key", {8'd0, key_out}, 32'd3);

        // Scenario B: no valid key; restart clears done in the same cycle.
        for (int k = 0; k < NKEYS; k++) fillBad(k, (k % 2 == 0) ? 8'h60 : 8'h7B);
        applyStimulus();
        checkOutput("restart_done", {31'd0, done}, 32'd0);
        checkOutput("restart_found", {31'd0, key_found}, 32'd0);
        checkOutput("restart_init", {31'd0, init_start}, 32'd1);
        checkOutput("restart_key", {8'd0, key_out}, 32'd0);
        checkResult("b");

        // Reset during DEC aborts at once; a new search restarts at key 0.
        loadScenarioA();
        start = 1'b0;
        step(1);
        start = 1'b1;
        waitFor(2, 1'b1, "r_dec_start");
        reset = 1'b1;
        #1;
        checkOutput("rmid_starts", {29'd0, init_start, shuf_start, dec_start}, 32'd0);
        checkOutput("rmid_done", {31'd0, done}, 32'd0);
        step(2);
        reset = 1'b0;
        step(1);
        checkOutput("rpost_init", {31'd0, init_start}, 32'd1);
        checkOutput("rpost_key", {8'd0, key_out}, 32'd0);
        checkResult("r");

        // Randomized messages against the reference rule.
        for (int t = 0; t < 5; t++) begin
            for (int k = 0; k < NKEYS; k++) begin
                if ($urandom_range(0, 2) == 0) fillGood(k);
                else fillBad(k, rand_bad());
            end
            applyStimulus();
            checkResult($sformatf("rnd%0d", t));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rc4_crack_ctrl.md
Name: rc4_crack_ctrl

Overview:
- Brute-force key-search sequencer for the RC4 datapath.
- For each candidate key it runs, in order: the scratchpad init block, shuffle_arr, then decrypter.
- Owns the single scratch RAM port and grants it to the active stage.
- Checks every decrypted byte and stops on the first key whose whole message is lowercase letters or spaces.

Parameters:
- DATA_WIDTH, 8, scratch/message data width; fixed at 8.
- ADDR_WIDTH, 8, scratch/message address width.
- MESSAGE_LEN, 32, decrypted message length in bytes.
- KEY_WIDTH, 24, key width passed to shuffle_arr.
- KEY_START, 24'h000000, first candidate key.
- KEY_END, 24'h3FFFFF, last candidate key, inclusive.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous active-high reset
- start  in  1  search request; a rising edge starts a search
- done  out  1  search finished; held high
- key_found  out  1  valid with done: 1 = key located
- key_out  out  KEY_WIDTH  current candidate; the winning key once done
- init_start / init_finish  out / in  1 / 1  init block handshake
- shuf_start / shuf_finish  out / in  1 / 1  shuffle_arr handshake
- dec_start / dec_finish  out / in  1 / 1  decrypter handshake
- init_s_addr, init_s_data, init_s_wren  in  ADDR_WIDTH, DATA_WIDTH, 1  init scratch request
- shuf_s_addr, shuf_s_data, shuf_s_wren  in  ADDR_WIDTH, DATA_WIDTH, 1  shuffle scratch request
- dec_s_addr, dec_s_data, dec_s_wren  in  ADDR_WIDTH, DATA_WIDTH, 1  decrypter scratch request
- s_addr, s_data, s_wren  out  ADDR_WIDTH, DATA_WIDTH, 1  to scratch RAM; s_q is wired directly to all stages
- res_addr, res_data, res_wren  in  ADDR_WIDTH, DATA_WIDTH, 1  decrypter result-RAM write, snooped

Behaviour:
- Reset values:
  - state IDLE, all *_start 0, done 0, key_found 0.
  - key_out = KEY_START; bad flag 0.
  - Reset mid-search aborts immediately; sub-blocks see their start drop.
- Sub-block handshake is 4-phase:
  - Raise X_start.
  - Wait for X_finish = 1, then drop X_start the next cycle.
  - Wait for X_finish = 0, then advance.
  - X_start never re-rises while X_finish = 1.
- FSM: IDLE -> INIT -> SHUF -> DEC -> CHECK -> (INIT | DONE).
  - IDLE: on a rising edge of start, clear bad, load key_out = KEY_START, go to INIT.
  - INIT, SHUF, DEC: each runs its handshake, then moves to the next state.
  - Entering DEC clears bad.
  - CHECK, single cycle:
    - bad = 0: key_found = 1, go to DONE.
    - Else if key_out == KEY_END: key_found = 0, go to DONE.
    - Else key_out += 1 and go to INIT.
  - DONE: done = 1; done, key_found and key_out are held.
  - From DONE, a new start rising edge restarts from KEY_START and clears done/key_found in the same cycle.
- start held high does not retrigger; edge detection uses a registered copy of start.
- Scratch mux is combinational from the registered state:
  - INIT selects init_*; SHUF selects shuf_*; DEC selects dec_*.
  - All other states drive s_wren = 0, s_addr = 0, s_data = 0.
  - A request from a non-granted stage is ignored.
- Checker runs only in DEC.
  - It acts when res_wren = 1 and res_addr < MESSAGE_LEN.
  - bad is set if res_data is neither 8'h20 nor within 8'h61..8'h7A.
  - bad is sticky until the next DEC entry.
  - Writes at addresses >= MESSAGE_LEN are ignored.
- No early abort: a bad key still completes DEC before CHECK.
- KEY_START == KEY_END: exactly one iteration.
- Key increment uses KEY_WIDTH bits; there is no wrap past KEY_END.

Optional Feature:
- Macro: RC4_CRACK_STATS_EN.
- When defined, adds output keys_tried [KEY_WIDTH:0]:
  - Cleared on reset and on each search start.
  - Incremented on every CHECK cycle and held in DONE.
- Without it, the port and counter do not exist and behaviour is otherwise identical.

Decomposition:
- Package rc4_pkg holds:
  - the state enum (IDLE, INIT, SHUF, DEC, CHECK, DONE);
  - CHAR_SPACE = 8'h20, CHAR_LO = 8'h61, CHAR_HI = 8'h7A;
  - a default MESSAGE_LEN constant.
- One sub-module, msg_char_checker: the sticky bad-flag logic with clear/enable inputs.

Test Plan:
- Stub stages finish 3 cycles after start. KEY_START = 0, KEY_END = 5, decrypter stub writes valid "ab cd..." only for key 3 -> done = 1, key_found = 1, key_out = 3, four CHECK visits.
- Same setup, no valid key -> done = 1, key_found = 0, key_out = 5 after six iterations.
- Check s_addr/s_wren in each state.
  - During SHUF, drive init_s_wren = 1 -> s_wren follows shuf_s_wren only.
  - In CHECK, s_wren = 0.
- Checker boundaries:
  - Result bytes 8'h60 and 8'h7B -> bad.
  - Bytes 8'h20, 8'h61, 8'h7A -> not bad.
  - A write at address 32 of 8'h00 -> ignored.
- Assert reset mid-DEC -> all *_start = 0 and done = 0 in the same cycle. A new start then begins at key 0.
- Hold start high through DONE -> no restart. Toggle start low then high -> new search, done cleared. With RC4_CRACK_STATS_EN, keys_tried = 4 for the first scenario.
